// File: rtl/rps_pkg.sv
// Shared hand codes and FSM state encoding for the RPS hand encoder and
// the display decoder that consumes its HAND output.
package rps_pkg;

    typedef enum logic [1:0] {
        ROCK     = 2'b00,
        PAPER    = 2'b01,
        SCISSORS = 2'b10,
        NONE     = 2'b11
    } hand_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        SHOWN = 2'b10
    } state_t;

    // Maps a one-hot debounced button vector {scissors, paper, rock} to its hand code.
    function automatic hand_t btn_to_hand(input logic [2:0] btn);
        hand_t h;
        case (btn)
            3'b001:  h = ROCK;
            3'b010:  h = PAPER;
            3'b100:  h = SCISSORS;
            default: h = NONE;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/rps_hand_encoder_if.sv
// Button inputs and hand/status outputs of the RPS hand encoder.
interface rps_hand_encoder_if;
    logic [2:0] BTN;
    logic       GO1;
    logic       GO2;
    logic       CLR;
    logic [1:0] HAND;
    logic       CHOSEN;
    logic       SHOW;

    modport master (output BTN, GO1, GO2, CLR, input HAND, CHOSEN, SHOW);
    modport slave  (input BTN, GO1, GO2, CLR, output HAND, CHOSEN, SHOW);
endinterface

// File: rtl/rps_debounce.sv
// One raw asynchronous button: 2-flop synchronizer, counting debouncer,
// stable level and a one-cycle rising-edge pulse.
module rps_debounce #(
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    localparam int unsigned    CW       = ($clog2(DB_CYCLES + 1) < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic          en_q;

    // Counter stops at CNT_LAST: that is the cycle the level flips, so it never wraps.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q[1] == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            stable_d = sync_q[1];
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Edges are only honoured once a genuine low has come through the
    // refilled synchronizer, so a button held across reset cannot pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            fill_q   <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            en_q     <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], raw_i};
            fill_q   <= {fill_q[0], 1'b1};
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            en_q     <= en_q | (fill_q[1] & ~sync_q[1]);
        end
    end

    assign level_o = stable_q;
    assign rise_o  = stable_q & ~prev_q & en_q;

endmodule

// File: rtl/rps_hand_encoder.sv
// Rock/paper/scissors hand encoder: latches one debounced choice, reveals it
// when both reveal buttons are held, and clears on the new-round button.
module rps_hand_encoder
    import rps_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 50000
) (
    input  logic CLK,
    input  logic RST,
    rps_hand_encoder_if.slave bus
);
    localparam int CH_GO1 = 3;
    localparam int CH_GO2 = 4;
    localparam int CH_CLR = 5;

    logic [5:0] raw_in;
    logic [5:0] lvl;
    logic [5:0] rise;

    assign raw_in = {bus.CLR, bus.GO2, bus.GO1, bus.BTN};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_db
            rps_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clk     (CLK),
                .rst     (RST),
                .raw_i   (raw_in[gi]),
                .level_o (lvl[gi]),
                .rise_o  (rise[gi])
            );
        end
    endgenerate

    state_t     state_q, state_d;
    hand_t      code_q, code_d;
    logic [1:0] hand_q, hand_d;
    logic       chosen_q, chosen_d;
    logic       show_q, show_d;

    // A choice is accepted only when the rising button is the sole button held.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (rise[CH_CLR]) begin
            state_d = IDLE;
            code_d  = NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if ($onehot(lvl[2:0]) && (rise[2:0] == lvl[2:0])) begin
                        code_d  = btn_to_hand(lvl[2:0]);
                        state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (lvl[CH_GO1] && lvl[CH_GO2]) begin
                        state_d = SHOWN;
                    end
                end
                SHOWN: begin
                    state_d = SHOWN;
                end
                default: begin
                    state_d = IDLE;
                    code_d  = NONE;
                end
            endcase
        end

        hand_d   = (state_d == SHOWN) ? code_d : NONE;
        chosen_d = (state_d != IDLE);
        show_d   = (state_d == SHOWN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            code_q   <= NONE;
            hand_q   <= NONE;
            chosen_q <= 1'b0;
            show_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            hand_q   <= hand_d;
            chosen_q <= chosen_d;
            show_q   <= show_d;
        end
    end

    assign bus.HAND   = hand_q;
    assign bus.CHOSEN = chosen_q;
    assign bus.SHOW   = show_q;

endmodule

// File: tb/tb_rps_hand_encoder.sv
// Bench for rps_hand_encoder with DB_CYCLES=4: directed scenarios plus random
// button activity, all checked every cycle against a window-based model.
module tb_rps_hand_encoder;
    localparam int DB = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    rps_hand_encoder_if bus ();

    rps_hand_encoder #(.DB_CYCLES(DB)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raw samples per edge; a debounced level flips when the
    // last DB synchronized samples (two edges old) all disagree with it.
    int         e = 0;
    int         last_rst = 0;
    logic [5:0] hist [0:8191];
    logic [5:0] m_stab = '0;
    logic [5:0] m_rise = '0;
    logic [5:0] m_seen = '0;
    int         phase = 0;
    logic [1:0] code = 2'b11;

    task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (edge %0d)", tag, got, exp, e);
        end
    endtask

    function automatic logic hv(input int k, input int ch);
        if (k <= last_rst) return 1'b0;
        return hist[k][ch];
    endfunction

    task automatic model_step();
        logic [5:0] raw;
        logic       all_opp;
        raw = {bus.CLR, bus.GO2, bus.GO1, bus.BTN};
        e++;
        if (RST) begin
            last_rst = e;
            m_stab   = '0;
            m_rise   = '0;
            m_seen   = '0;
            phase    = 0;
            code     = 2'b11;
            return;
        end
        hist[e] = raw;
        if (m_rise[5]) begin
            phase = 0;
            code  = 2'b11;
        end else if (phase == 0) begin
            for (int b = 0; b < 3; b++) begin
                if (m_rise[b] && (m_stab[2:0] == (3'b001 << b))) begin
                    phase = 1;
                    code  = b[1:0];
                end
            end
        end else if (phase == 1 && m_stab[3] && m_stab[4]) begin
            phase = 2;
        end
        for (int ch = 0; ch < 6; ch++) begin
            if ((e - 2 > last_rst) && !hist[e-2][ch]) m_seen[ch] = 1'b1;
            all_opp = 1'b1;
            for (int k = e - 1 - DB; k <= e - 2; k++) begin
                if (hv(k, ch) == m_stab[ch]) all_opp = 1'b0;
            end
            m_rise[ch] = 1'b0;
            if (all_opp) begin
                m_stab[ch] = ~m_stab[ch];
                m_rise[ch] = m_stab[ch] & m_seen[ch];
            end
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
        check_val("HAND",   bus.HAND,           (phase == 2) ? code : 2'b11);
        check_val("CHOSEN", {1'b0, bus.CHOSEN}, {1'b0, phase != 0});
        check_val("SHOW",   {1'b0, bus.SHOW},   {1'b0, phase == 2});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic set_in(input logic [2:0] btn, input logic go1, input logic go2, input logic clr);
        bus.BTN = btn;
        bus.GO1 = go1;
        bus.GO2 = go2;
        bus.CLR = clr;
    endtask

    task automatic do_reset();
        set_in(3'b000, 1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        run(2);
        RST = 1'b0;
        run(4);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] hand, input logic chosen, input logic show);
        check_val({tag, "_hand"},   bus.HAND,           hand);
        check_val({tag, "_chosen"}, {1'b0, bus.CHOSEN}, {1'b0, chosen});
        check_val({tag, "_show"},   {1'b0, bus.SHOW},   {1'b0, show});
    endtask

    initial begin
        set_in(3'b000, 1'b0, 1'b0, 1'b0);

        // Reset state and paper choice with exact latency
        do_reset();
        expect_out("reset", 2'b11, 1'b0, 1'b0);
        set_in(3'b010, 1'b0, 1'b0, 1'b0);
        run(6);
        expect_out("paper_pre", 2'b11, 1'b0, 1'b0);
        cyc();
        expect_out("paper_armed", 2'b11, 1'b1, 1'b0);
        run(3);
        set_in(3'b000, 1'b1, 1'b1, 1'b0);
        run(6);
        expect_out("paper_prereveal", 2'b11, 1'b1, 1'b0);
        cyc();
        expect_out("paper_shown", 2'b01, 1'b1, 1'b1);
        $display("scenario paper_reveal done at edge %0d", e);

        // Glitch shorter than the debounce window
        do_reset();
        set_in(3'b001, 1'b0, 1'b0, 1'b0);
        run(3);
        set_in(3'b000, 1'b0, 1'b0, 1'b0);
        run(12);
        expect_out("glitch", 2'b11, 1'b0, 1'b0);
        $display("scenario glitch done at edge %0d", e);

        // Two buttons together are ignored, then scissors alone
        do_reset();
        set_in(3'b101, 1'b0, 1'b0, 1'b0);
        run(12);
        expect_out("dual", 2'b11, 1'b0, 1'b0);
        set_in(3'b000, 1'b0, 1'b0, 1'b0);
        run(12);
        set_in(3'b100, 1'b0, 1'b0, 1'b0);
        run(12);
        expect_out("sc_armed", 2'b11, 1'b1, 1'b0);
        set_in(3'b000, 1'b1, 1'b1, 1'b0);
        run(10);
        expect_out("sc_shown", 2'b10, 1'b1, 1'b1);
        $display("scenario dual_then_scissors done at edge %0d", e);

        // Choice locked while armed, then CLR wins over held GO
        do_reset();
        set_in(3'b001, 1'b0, 1'b0, 1'b0);
        run(12);
        set_in(3'b000, 1'b0, 1'b0, 1'b0);
        run(10);
        set_in(3'b100, 1'b0, 1'b0, 1'b0);
        run(12);
        expect_out("lock_armed", 2'b11, 1'b1, 1'b0);
        set_in(3'b000, 1'b1, 1'b1, 1'b0);
        run(10);
        expect_out("lock_shown", 2'b00, 1'b1, 1'b1);
        set_in(3'b000, 1'b1, 1'b1, 1'b1);
        run(10);
        expect_out("clr_idle", 2'b11, 1'b0, 1'b0);
        $display("scenario lock_and_clear done at edge %0d", e);

        // Reset in SHOWN with paper held: no choice until released and repressed
        do_reset();
        set_in(3'b010, 1'b0, 1'b0, 1'b0);
        run(10);
        set_in(3'b010, 1'b1, 1'b1, 1'b0);
        run(10);
        expect_out("pre_rst_shown", 2'b01, 1'b1, 1'b1);
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        expect_out("rst_in_shown", 2'b11, 1'b0, 1'b0);
        run(20);
        expect_out("held_after_rst", 2'b11, 1'b0, 1'b0);
        set_in(3'b000, 1'b1, 1'b1, 1'b0);
        run(10);
        set_in(3'b010, 1'b1, 1'b1, 1'b0);
        run(10);
        expect_out("repress", 2'b01, 1'b1, 1'b1);
        $display("scenario reset_in_shown done at edge %0d", e);

        // Random activity, checked every cycle by the model
        do_reset();
        for (int s = 0; s < 250; s++) begin
            int sel;
            logic [2:0] btn;
            sel = int'($urandom_range(0, 4));
            if (sel == 0)      btn = 3'b000;
            else if (sel == 4) btn = 3'($urandom_range(0, 7));
            else               btn = 3'b001 << (sel - 1);
            set_in(btn, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                   $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) begin
                RST = 1'b1;
                cyc();
                RST = 1'b0;
            end else begin
                run(int'($urandom_range(1, 9)));
            end
        end
        $display("scenario random done at edge %0d", e);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
